// File: rtl/multi_counter_sched.sv
// multi_counter_sched: init sweep, round-robin command arbiter and
// query-response router in front of the multi_counter state table.
// Ports: clk, rst (async, low), clr; req_vld/rdy/id/op/dat per
// requester; cntr_* command port; status_* from multi_counter;
// rsp_vld_r (one-hot), rsp_id_r, rsp_dat_r query responses.
package multi_counter_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INIT = 3'd1,
    OP_SET  = 3'd2,
    OP_INCR = 3'd3,
    OP_DECR = 3'd4,
    OP_QRY  = 3'd5
  } op_t;
endpackage

module multi_counter_sched
  import multi_counter_pkg::*;
#(
  parameter int REQ_N = 4,
  parameter int CNTRS_N = 256,
  parameter int CNTRS_W = 32,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N),
  parameter int LAT = 4,
  parameter logic [CNTRS_W-1:0] INIT_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic init_done_r,
  input  logic [REQ_N-1:0] req_vld,
  output logic [REQ_N-1:0] req_rdy,
  input  logic [REQ_N-1:0][CNTRS_ID_W-1:0] req_id,
  input  op_t  [REQ_N-1:0] req_op,
  input  logic [REQ_N-1:0][CNTRS_W-1:0] req_dat,
  output logic cntr_pass,
  output logic [CNTRS_ID_W-1:0] cntr_id,
  output op_t  cntr_op,
  output logic [CNTRS_W-1:0] cntr_dat,
  input  logic status_pass_r,
  input  logic status_qry_r,
  input  logic [CNTRS_ID_W-1:0] status_id_r,
  input  logic [CNTRS_W-1:0] status_dat_r,
  output logic [REQ_N-1:0] rsp_vld_r,
  output logic [CNTRS_ID_W-1:0] rsp_id_r,
  output logic [CNTRS_W-1:0] rsp_dat_r
);

  localparam int IDX_W = $clog2(REQ_N);
  localparam int PTR_W = CNTRS_ID_W + 1;
  localparam logic [PTR_W-1:0] LAST_ID =
    PTR_W'(CNTRS_N - 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [REQ_N-1:0] ONE =
    {{(REQ_N-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] RR_RST = IDX_W'(REQ_N - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic init_done_q, init_done_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
  logic [REQ_N-1:0] rsp_vld_q, rsp_vld_d;
  logic [CNTRS_ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [CNTRS_W-1:0] rsp_dat_q, rsp_dat_d;

  logic gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic st_init;
  logic issue;
  logic rsp_fire;

  // circular search starting just after the last grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = 1; k <= REQ_N; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % REQ_N);
      if (!gnt_vld && req_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign st_init = (state_q == ST_INIT);
  assign issue = !st_init && !clr && gnt_vld;

  always_comb begin
    cntr_pass = 1'b0;
    cntr_op = OP_NOP;
    cntr_id = '0;
    cntr_dat = '0;
    req_rdy = '0;
    unique case (1'b1)
      st_init: begin
        cntr_pass = 1'b1;
        cntr_op = OP_INIT;
        cntr_id = ptr_q[CNTRS_ID_W-1:0];
        cntr_dat = INIT_VAL;
      end
      issue: begin
        cntr_pass = 1'b1;
        cntr_op = req_op[gnt_idx];
        cntr_id = req_id[gnt_idx];
        cntr_dat = req_dat[gnt_idx];
        req_rdy = ONE << gnt_idx;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    rr_d = rr_q;
    unique case (state_q)
      ST_INIT: begin
        if (clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_ID) begin
          ptr_d = '0;
          state_d = ST_RUN;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_INIT;
          ptr_d = '0;
        end else if (gnt_vld) begin
          rr_d = gnt_idx;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign init_done_d = (state_d == ST_RUN);

  // owner of each in-flight command, aligned with status latency
  always_comb begin
    tag_vld_d = '0;
    tag_idx_d = '0;
    tag_vld_d[0] = issue;
    tag_idx_d[0] = gnt_idx;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  // a query status only ever arrives together with pass
  assign rsp_fire = status_pass_r && status_qry_r
                 && tag_vld_q[LAT-1];

  always_comb begin
    rsp_vld_d = '0;
    rsp_id_d = rsp_id_q;
    rsp_dat_d = rsp_dat_q;
    if (rsp_fire) begin
      rsp_vld_d = ONE << tag_idx_q[LAT-1];
      rsp_id_d = status_id_r;
      rsp_dat_d = status_dat_r;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      ptr_q <= '0;
      rr_q <= RR_RST;
      init_done_q <= 1'b0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      rsp_vld_q <= '0;
      rsp_id_q <= '0;
      rsp_dat_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      rr_q <= rr_d;
      init_done_q <= init_done_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q <= rsp_id_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign init_done_r = init_done_q;
  assign rsp_vld_r = rsp_vld_q;
  assign rsp_id_r = rsp_id_q;
  assign rsp_dat_r = rsp_dat_q;

  qry_has_owner_a: assert property (
    @(posedge clk) disable iff (!rst)
    status_qry_r |-> tag_vld_q[LAT-1]
  );

endmodule

// File: tb/tb_multi_counter_sched.sv
// tb_multi_counter_sched: directed bench for multi_counter_sched
// with a small behavioural multi_counter behind the command port.
module tb_multi_counter_sched;
  import multi_counter_pkg::*;

  localparam int REQ_N = 4;
  localparam int CNTRS_N = 8;
  localparam int W = 32;
  localparam int ID_W = 3;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic init_done_r;
  logic [REQ_N-1:0] req_vld;
  logic [REQ_N-1:0] req_rdy;
  logic [REQ_N-1:0][ID_W-1:0] req_id;
  op_t  [REQ_N-1:0] req_op;
  logic [REQ_N-1:0][W-1:0] req_dat;
  logic cntr_pass;
  logic [ID_W-1:0] cntr_id;
  op_t  cntr_op;
  logic [W-1:0] cntr_dat;
  logic status_pass_r;
  logic status_qry_r;
  logic [ID_W-1:0] status_id_r;
  logic [W-1:0] status_dat_r;
  logic [REQ_N-1:0] rsp_vld_r;
  logic [ID_W-1:0] rsp_id_r;
  logic [W-1:0] rsp_dat_r;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  multi_counter_sched #(
    .REQ_N(REQ_N),
    .CNTRS_N(CNTRS_N),
    .CNTRS_W(W),
    .CNTRS_ID_W(ID_W),
    .LAT(LAT),
    .INIT_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .init_done_r(init_done_r),
    .req_vld(req_vld),
    .req_rdy(req_rdy),
    .req_id(req_id),
    .req_op(req_op),
    .req_dat(req_dat),
    .cntr_pass(cntr_pass),
    .cntr_id(cntr_id),
    .cntr_op(cntr_op),
    .cntr_dat(cntr_dat),
    .status_pass_r(status_pass_r),
    .status_qry_r(status_qry_r),
    .status_id_r(status_id_r),
    .status_dat_r(status_dat_r),
    .rsp_vld_r(rsp_vld_r),
    .rsp_id_r(rsp_id_r),
    .rsp_dat_r(rsp_dat_r)
  );

  typedef struct packed {
    logic pass;
    logic qry;
    logic [ID_W-1:0] id;
    logic [W-1:0] dat;
  } st_t;

  st_t pipe [LAT];
  logic [W-1:0] mem [CNTRS_N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      pipe[0].pass <= cntr_pass && (cntr_op != OP_NOP);
      pipe[0].qry <= cntr_pass && (cntr_op == OP_QRY);
      pipe[0].id <= cntr_id;
      pipe[0].dat <= mem[cntr_id];
      if (cntr_pass) begin
        case (cntr_op)
          OP_INIT: mem[cntr_id] <= '0;
          OP_SET:  mem[cntr_id] <= cntr_dat;
          OP_INCR: mem[cntr_id] <= mem[cntr_id] + 1;
          OP_DECR: mem[cntr_id] <= mem[cntr_id] - 1;
          default: ;
        endcase
      end
    end
  end

  assign status_pass_r = pipe[LAT-1].pass;
  assign status_qry_r = pipe[LAT-1].qry;
  assign status_id_r = pipe[LAT-1].id;
  assign status_dat_r = pipe[LAT-1].dat;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic sweep_chk(input int i);
    chk($sformatf("sweep%0d_pass", i), 64'(cntr_pass), 1);
    chk($sformatf("sweep%0d_op", i), 64'(cntr_op), 64'(OP_INIT));
    chk($sformatf("sweep%0d_id", i), 64'(cntr_id), 64'(i));
    chk($sformatf("sweep%0d_dat", i), 64'(cntr_dat), 0);
    chk($sformatf("sweep%0d_rdy", i), 64'(req_rdy), 0);
    chk($sformatf("sweep%0d_done", i), 64'(init_done_r), 0);
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    clr = 1'b0;
    req_vld = '0;
    for (int i = 0; i < REQ_N; i++) begin
      req_id[i] = ID_W'(i + 1);
      req_op[i] = OP_NOP;
      req_dat[i] = W'(16 * i + 7);
    end
    #2;
    chk("rst_done", 64'(init_done_r), 0);
    chk("rst_rsp_vld", 64'(rsp_vld_r), 0);
    chk("rst_rsp_id", 64'(rsp_id_r), 0);
    chk("rst_rsp_dat", 64'(rsp_dat_r), 0);
    chk("rst_rdy", 64'(req_rdy), 0);

    // sweep after reset, all requesters already asking
    repeat (2) cyc();
    rst = 1'b1;
    req_vld = 4'hf;
    #1;
    for (int i = 0; i < CNTRS_N; i++) begin
      if (i > 0) begin cyc(); #1; end
      sweep_chk(i);
    end

    // round robin 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      if (k == 0) chk("done_rise", 64'(init_done_r), 1);
      chk($sformatf("rr%0d_rdy", k), 64'(req_rdy),
          64'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_pass", k), 64'(cntr_pass), 1);
      chk($sformatf("rr%0d_op", k), 64'(cntr_op), 64'(OP_NOP));
      chk($sformatf("rr%0d_id", k), 64'(cntr_id),
          64'(k % 4 + 1));
      chk($sformatf("rr%0d_dat", k), 64'(cntr_dat),
          64'(16 * (k % 4) + 7));
      chk($sformatf("rr%0d_rsp", k), 64'(rsp_vld_r), 0);
    end

    // req 2: three INCR of id 5, then query
    cyc();
    req_vld = 4'b0100;
    req_op[2] = OP_INCR;
    req_id[2] = 3'd5;
    req_dat[2] = 32'd1;
    #1;
    chk("inc_rdy0", 64'(req_rdy), 64'(4'b0100));
    chk("inc_op", 64'(cntr_op), 64'(OP_INCR));
    chk("inc_id", 64'(cntr_id), 5);
    cyc(); #1;
    chk("inc_rdy1", 64'(req_rdy), 64'(4'b0100));
    cyc(); #1;
    chk("inc_rdy2", 64'(req_rdy), 64'(4'b0100));
    cyc();
    req_op[2] = OP_QRY;
    #1;
    chk("qry_rdy", 64'(req_rdy), 64'(4'b0100));
    chk("qry_op", 64'(cntr_op), 64'(OP_QRY));
    for (int k = 1; k <= LAT + 1; k++) begin
      cyc();
      if (k == 1) req_vld = '0;
      #1;
      chk($sformatf("qry_rsp_t%0d", k), 64'(rsp_vld_r),
          (k == LAT + 1) ? 64'(4'b0100) : 64'd0);
    end
    chk("qry_rsp_id", 64'(rsp_id_r), 5);
    chk("qry_rsp_dat", 64'(rsp_dat_r), 3);
    cyc(); #1;
    chk("qry_rsp_fall", 64'(rsp_vld_r), 0);
    chk("qry_id_hold", 64'(rsp_id_r), 5);
    chk("qry_dat_hold", 64'(rsp_dat_r), 3);

    // req 1 bumps id 1 twice; req 0 then req 3 query it
    cyc();
    req_vld = 4'b0010;
    req_op[1] = OP_INCR;
    req_id[1] = 3'd1;
    #1;
    chk("b2b_inc_rdy0", 64'(req_rdy), 64'(4'b0010));
    cyc(); #1;
    chk("b2b_inc_rdy1", 64'(req_rdy), 64'(4'b0010));
    cyc();
    req_vld = 4'b0001;
    req_op[0] = OP_QRY;
    req_id[0] = 3'd1;
    #1;
    chk("b2b_rdy0", 64'(req_rdy), 64'(4'b0001));
    cyc();
    req_vld = 4'b1000;
    req_op[3] = OP_QRY;
    req_id[3] = 3'd1;
    #1;
    chk("b2b_rdy3", 64'(req_rdy), 64'(4'b1000));
    cyc();
    req_vld = '0;
    cyc();
    cyc(); #1;
    chk("b2b_early", 64'(rsp_vld_r), 0);
    cyc(); #1;
    chk("b2b_rsp0", 64'(rsp_vld_r), 64'(4'b0001));
    chk("b2b_id0", 64'(rsp_id_r), 1);
    chk("b2b_dat0", 64'(rsp_dat_r), 2);
    cyc(); #1;
    chk("b2b_rsp3", 64'(rsp_vld_r), 64'(4'b1000));
    chk("b2b_id3", 64'(rsp_id_r), 1);
    chk("b2b_dat3", 64'(rsp_dat_r), 2);
    cyc(); #1;
    chk("b2b_fall", 64'(rsp_vld_r), 0);

    // query in flight, then clr with req 1 pending
    cyc();
    req_vld = 4'b0100;
    req_op[2] = OP_QRY;
    req_id[2] = 3'd5;
    #1;
    chk("clr_qry_rdy", 64'(req_rdy), 64'(4'b0100));
    cyc();
    req_vld = 4'b0010;
    req_op[1] = OP_INCR;
    req_id[1] = 3'd0;
    clr = 1'b1;
    #1;
    chk("clr_no_rdy", 64'(req_rdy), 0);
    chk("clr_no_pass", 64'(cntr_pass), 0);
    chk("clr_done_hi", 64'(init_done_r), 1);
    cyc();
    clr = 1'b0;
    #1;
    for (int i = 0; i < CNTRS_N; i++) begin
      if (i > 0) begin cyc(); #1; end
      sweep_chk(i);
      if (i == 3) begin
        chk("clr_rsp_vld", 64'(rsp_vld_r), 64'(4'b0100));
        chk("clr_rsp_id", 64'(rsp_id_r), 5);
      end
    end
    cyc(); #1;
    chk("clr_done_rise", 64'(init_done_r), 1);
    chk("clr_gnt1", 64'(req_rdy), 64'(4'b0010));
    chk("clr_gnt1_op", 64'(cntr_op), 64'(OP_INCR));
    chk("clr_gnt1_id", 64'(cntr_id), 0);
    cyc();
    req_vld = '0;
    #1;
    chk("idle_pass", 64'(cntr_pass), 0);
    chk("idle_op", 64'(cntr_op), 64'(OP_NOP));

    // async reset in the middle of a sweep
    cyc();
    clr = 1'b1;
    #1;
    chk("clr2_pass", 64'(cntr_pass), 0);
    cyc();
    clr = 1'b0;
    for (int i = 0; i < REQ_N; i++) req_op[i] = OP_NOP;
    req_vld = 4'hf;
    #1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin cyc(); #1; end
      sweep_chk(i);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("arst_done", 64'(init_done_r), 0);
    chk("arst_rsp_vld", 64'(rsp_vld_r), 0);
    chk("arst_rsp_id", 64'(rsp_id_r), 0);
    chk("arst_rsp_dat", 64'(rsp_dat_r), 0);
    chk("arst_id", 64'(cntr_id), 0);
    chk("arst_rdy", 64'(req_rdy), 0);
    cyc();
    rst = 1'b1;
    #1;
    for (int i = 0; i < CNTRS_N; i++) begin
      if (i > 0) begin cyc(); #1; end
      sweep_chk(i);
    end
    cyc(); #1;
    chk("arst_done_rise", 64'(init_done_r), 1);
    chk("arst_rr_first", 64'(req_rdy), 64'(4'b0001));
    req_vld = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
